pc_redirect_ctrl: RTL

//  Next-PC sequencer in front of the PC register. Arbitrates redirect sources:

---
 rtl/pc_redirect_ctrl.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/pc_redirect_ctrl.sv
// Next-PC sequencer: arbitrates trap/MRET/mispredict/predicted/sequential targets,
// holds redirects that arrive during a stall, and runs the WFI sleep state machine.
module pc_redirect_ctrl #(
    parameter int              XLEN         = 32,
    parameter logic [XLEN-1:0] RESET_VECTOR = '0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stall,
    input  logic [XLEN-1:0] pc,
    input  logic            trap_req,
    input  logic [XLEN-1:0] trap_vec,
    input  logic            mret_req,
    input  logic [XLEN-1:0] mepc,
    input  logic            br_mispredict,
    input  logic [XLEN-1:0] br_target,
    input  logic            pred_taken,
    input  logic [XLEN-1:0] pred_target,
    input  logic            wfi_req,
    input  logic            irq_pending,
    output logic [XLEN-1:0] pc_next,
    output logic            pc_we,
    output logic            flush,
    output logic            sleeping,
    output logic            redirect_pending
);

    typedef enum logic [1:0] {
        S_RUN   = 2'd0,
        S_PEND  = 2'd1,
        S_SLEEP = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic            pend_valid_q, pend_valid_d;
    logic [1:0]      pend_prio_q, pend_prio_d;
    logic [XLEN-1:0] pend_target_q, pend_target_d;

    logic [1:0]      live_prio;
    logic [XLEN-1:0] live_target;
    logic [XLEN-1:0] seq_pc;

    // Wraps naturally at 2^XLEN; the carry is simply dropped.
    assign seq_pc = pc + XLEN'(4);

    // Live flushing redirect: trap(3) > mret(2) > mispredict(1); 0 means none.
    always_comb begin
        live_prio   = 2'd0;
        live_target = '0;
        if (trap_req) begin
            live_prio   = 2'd3;
            live_target = trap_vec;
        end else if (mret_req) begin
            live_prio   = 2'd2;
            live_target = mepc;
        end else if (br_mispredict) begin
            live_prio   = 2'd1;
            live_target = br_target;
        end
    end

    always_comb begin
        state_d       = state_q;
        pend_valid_d  = pend_valid_q;
        pend_prio_d   = pend_prio_q;
        pend_target_d = pend_target_q;
        pc_next       = seq_pc;
        pc_we         = 1'b0;
        flush         = 1'b0;

        case (state_q)
            S_RUN: begin
                if (!stall) begin
                    pc_we = 1'b1;
                    if (live_prio != 2'd0) begin
                        pc_next = live_target;
                        flush   = 1'b1;
                    end else if (pred_taken) begin
                        pc_next = pred_target;
                    end
                    if (wfi_req && (live_prio == 2'd0) && !irq_pending) begin
                        state_d = S_SLEEP;
                    end
                end else if (live_prio != 2'd0) begin
                    pend_valid_d  = 1'b1;
                    pend_prio_d   = live_prio;
                    pend_target_d = live_target;
                    state_d       = S_PEND;
                end
            end
            S_PEND: begin
                if (stall) begin
                    if (live_prio > pend_prio_q) begin
                        pend_prio_d   = live_prio;
                        pend_target_d = live_target;
                    end
                end else begin
                    pc_we        = 1'b1;
                    flush        = 1'b1;
                    // Equal priority favours the fresher live request.
                    pc_next      = (live_prio >= pend_prio_q) ? live_target : pend_target_q;
                    pend_valid_d = 1'b0;
                    pend_prio_d  = 2'd0;
                    state_d      = S_RUN;
                end
            end
            S_SLEEP: begin
                if (trap_req) begin
                    if (stall) begin
                        pend_valid_d  = 1'b1;
                        pend_prio_d   = 2'd3;
                        pend_target_d = trap_vec;
                        state_d       = S_PEND;
                    end else begin
                        pc_we   = 1'b1;
                        flush   = 1'b1;
                        pc_next = trap_vec;
                        state_d = S_RUN;
                    end
                end else if (irq_pending) begin
                    state_d = S_RUN;
                end
            end
            default: begin
                state_d = S_RUN;
            end
        endcase

        if (rst) begin
            pc_next = RESET_VECTOR;
            pc_we   = 1'b0;
            flush   = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_RUN;
            pend_valid_q  <= 1'b0;
            pend_prio_q   <= 2'd0;
            pend_target_q <= '0;
        end else begin
            state_q       <= state_d;
            pend_valid_q  <= pend_valid_d;
            pend_prio_q   <= pend_prio_d;
            pend_target_q <= pend_target_d;
        end
    end

    assign sleeping         = (state_q == S_SLEEP);
    assign redirect_pending = pend_valid_q;

endmodule
